seq_decoder: RTL and testbench

//  Parametrised, multi-cycle successor to the picoMIPS single-cycle instruction decoder.

---
 rtl/seq_decoder.sv | 163 ++++++++++++++++
 tb/tb_seq_decoder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/seq_decoder.sv
// Multi-cycle picoMIPS instruction decoder: Mealy strobes for accumulator, switch input,
// register write and PC, with input handshake, multi-cycle MAC, HALT/resume and a retire counter.
module seq_decoder #(
    parameter int OPW        = 3,
    parameter int MAC_CYCLES = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic [OPW-1:0]   opcode,
    input  logic             z,
    input  logic             in_valid,
    input  logic             resume,
    output logic             acc_en,
    output logic             acc_add,
    output logic             in_en,
    output logic             w,
    output logic             pc_incr,
    output logic             pc_relbranch,
    output logic             busy,
    output logic             illegal_op,
    output logic             err,
    output logic [CNT_W-1:0] instr_count
);

    // state    | meaning
    // RUN      | decode opcode and issue strobes
    // WAIT_IN  | ACCI stalled until in_valid
    // MAC_BUSY | MACI counting down mac_cnt before the accumulate
    // HALTED   | stopped until resume

    localparam int MCW = (MAC_CYCLES > 0) ? $clog2(MAC_CYCLES + 1) : 1;
    localparam logic [MCW-1:0] MAC_INIT = (MAC_CYCLES > 0) ? MCW'(MAC_CYCLES - 1) : '0;

    localparam logic [OPW-1:0] OP_NOP  = OPW'(0);
    localparam logic [OPW-1:0] OP_ACCI = OPW'(1);
    localparam logic [OPW-1:0] OP_MACI = OPW'(2);
    localparam logic [OPW-1:0] OP_BEQ  = OPW'(3);
    localparam logic [OPW-1:0] OP_BNE  = OPW'(4);
    localparam logic [OPW-1:0] OP_JMP  = OPW'(5);
    localparam logic [OPW-1:0] OP_HALT = OPW'(6);

    typedef enum logic [1:0] {RUN, WAIT_IN, MAC_BUSY, HALTED} state_t;

    state_t           state_q, state_d;
    logic [MCW-1:0]   mac_cnt_q, mac_cnt_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] instr_count_q, instr_count_d;

    logic acc_en_c, acc_add_c, in_en_c, w_c, pc_incr_c, pc_rel_c, illegal_c;

    always_comb begin
        state_d   = state_q;
        mac_cnt_d = mac_cnt_q;
        acc_en_c  = 1'b0;
        acc_add_c = 1'b0;
        in_en_c   = 1'b0;
        w_c       = 1'b0;
        pc_incr_c = 1'b0;
        pc_rel_c  = 1'b0;
        illegal_c = 1'b0;
        case (state_q)
            RUN: begin
                case (opcode)
                    OP_NOP: pc_incr_c = 1'b1;
                    OP_ACCI: begin
                        if (in_valid) begin
                            acc_en_c  = 1'b1;
                            in_en_c   = 1'b1;
                            w_c       = 1'b1;
                            pc_incr_c = 1'b1;
                        end else begin
                            state_d = WAIT_IN;
                        end
                    end
                    OP_MACI: begin
                        if (MAC_CYCLES == 0) begin
                            acc_en_c  = 1'b1;
                            acc_add_c = 1'b1;
                            pc_incr_c = 1'b1;
                        end else begin
                            mac_cnt_d = MAC_INIT;
                            state_d   = MAC_BUSY;
                        end
                    end
                    OP_BEQ: begin
                        pc_rel_c  = z;
                        pc_incr_c = ~z;
                    end
                    OP_BNE: begin
                        pc_rel_c  = ~z;
                        pc_incr_c = z;
                    end
                    OP_JMP:  pc_rel_c = 1'b1;
                    OP_HALT: state_d  = HALTED;
                    default: begin
                        illegal_c = 1'b1;
                        pc_incr_c = 1'b1;
                    end
                endcase
            end
            WAIT_IN: begin
                if (in_valid) begin
                    acc_en_c  = 1'b1;
                    in_en_c   = 1'b1;
                    w_c       = 1'b1;
                    pc_incr_c = 1'b1;
                    state_d   = RUN;
                end
            end
            MAC_BUSY: begin
                if (mac_cnt_q == '0) begin
                    acc_en_c  = 1'b1;
                    acc_add_c = 1'b1;
                    pc_incr_c = 1'b1;
                    state_d   = RUN;
                end else begin
                    mac_cnt_d = mac_cnt_q - MCW'(1);
                end
            end
            HALTED: begin
                if (resume) begin
                    pc_incr_c = 1'b1;
                    state_d   = RUN;
                end
            end
            default: state_d = RUN;
        endcase

        err_d         = err_q | illegal_c;
        instr_count_d = instr_count_q;
        if ((pc_incr_c | pc_rel_c) && (instr_count_q != '1)) begin
            instr_count_d = instr_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q       <= RUN;
            mac_cnt_q     <= '0;
            err_q         <= 1'b0;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            mac_cnt_q     <= mac_cnt_d;
            err_q         <= err_d;
            instr_count_q <= instr_count_d;
        end
    end

    // Mealy strobes follow the inputs, so they are gated to stay quiet while reset is held.
    assign acc_en       = acc_en_c  & nReset;
    assign acc_add      = acc_add_c & nReset;
    assign in_en        = in_en_c   & nReset;
    assign w            = w_c       & nReset;
    assign pc_incr      = pc_incr_c & nReset;
    assign pc_relbranch = pc_rel_c  & nReset;
    assign illegal_op   = illegal_c & nReset;
    assign busy         = (state_q != RUN) & nReset;
    assign err          = err_q;
    assign instr_count  = instr_count_q;

endmodule

// File: tb/tb_seq_decoder.sv
// Bench for seq_decoder: vector table plus hand-written reset, MAC and saturation sequences,
// with expected strobes and counts queued at drive time and compared when sampled.
module tb_seq_decoder;

    logic       clk = 1'b0;
    logic       nReset;
    logic [2:0] opcode;
    logic       z, in_valid, resume;

    // {acc_en, acc_add, in_en, w, pc_incr, pc_relbranch, busy, illegal_op, err}
    logic [8:0]  o0, o1, o2;
    logic [15:0] c0, c1;
    logic [1:0]  c2;

    always #5 clk = ~clk;

    seq_decoder #(.OPW(3), .MAC_CYCLES(4), .CNT_W(16)) dut0 (
        .clk(clk), .nReset(nReset), .opcode(opcode), .z(z), .in_valid(in_valid), .resume(resume),
        .acc_en(o0[8]), .acc_add(o0[7]), .in_en(o0[6]), .w(o0[5]), .pc_incr(o0[4]),
        .pc_relbranch(o0[3]), .busy(o0[2]), .illegal_op(o0[1]), .err(o0[0]), .instr_count(c0));

    seq_decoder #(.OPW(3), .MAC_CYCLES(0), .CNT_W(16)) dut1 (
        .clk(clk), .nReset(nReset), .opcode(opcode), .z(z), .in_valid(in_valid), .resume(resume),
        .acc_en(o1[8]), .acc_add(o1[7]), .in_en(o1[6]), .w(o1[5]), .pc_incr(o1[4]),
        .pc_relbranch(o1[3]), .busy(o1[2]), .illegal_op(o1[1]), .err(o1[0]), .instr_count(c1));

    seq_decoder #(.OPW(3), .MAC_CYCLES(4), .CNT_W(2)) dut2 (
        .clk(clk), .nReset(nReset), .opcode(opcode), .z(z), .in_valid(in_valid), .resume(resume),
        .acc_en(o2[8]), .acc_add(o2[7]), .in_en(o2[6]), .w(o2[5]), .pc_incr(o2[4]),
        .pc_relbranch(o2[3]), .busy(o2[2]), .illegal_op(o2[1]), .err(o2[0]), .instr_count(c2));

    localparam logic [2:0] NOP = 3'd0, ACCI = 3'd1, MACI = 3'd2, BEQ = 3'd3,
                           BNE = 3'd4, JMP = 3'd5, HALT = 3'd6, ILL = 3'd7;

    typedef struct {
        logic [2:0] op;
        logic       z;
        logic       iv;
        logic       rs;
        logic [8:0] e;
    } vec_t;

    typedef struct {
        logic [8:0]  e;
        logic [15:0] c;
    } exp_t;

    vec_t        tbl[$];
    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_cnt = '0;

    function automatic logic [8:0] e(input logic a, b, c, d, f, g, h, i, j);
        return {a, b, c, d, f, g, h, i, j};
    endfunction

    function automatic vec_t mk(input logic [2:0] op, input logic zz, iv, rs, input logic [8:0] ex);
        vec_t v;
        v.op = op; v.z = zz; v.iv = iv; v.rs = rs; v.e = ex;
        return v;
    endfunction

    task automatic check_main(input string name);
        exp_t x;
        x = sb.pop_front();
        checks++;
        if (o0 !== x.e) begin
            errors++;
            $display("FAIL %s strobes got=%b want=%b", name, o0, x.e);
        end
        checks++;
        if (c0 !== x.c) begin
            errors++;
            $display("FAIL %s instr_count got=%0d want=%0d", name, c0, x.c);
        end
        if (x.e[4] | x.e[3]) exp_cnt = exp_cnt + 16'd1;
    endtask

    // Called at a falling edge; drives one cycle, checks mid-cycle, returns at the next falling edge.
    task automatic step(input string name, input logic [2:0] op, input logic zz, iv, rs,
                        input logic [8:0] ex);
        exp_t x;
        opcode = op; z = zz; in_valid = iv; resume = rs;
        x.e = ex; x.c = exp_cnt;
        sb.push_back(x);
        #2;
        check_main(name);
        @(negedge clk);
    endtask

    task automatic reset_pulse(input string name);
        #3;
        nReset = 1'b0;
        exp_cnt = '0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (o0 !== 9'd0 || c0 !== 16'd0) begin
                errors++;
                $display("FAIL %s in reset got=%b cnt=%0d want=0 cnt=0", name, o0, c0);
            end
            opcode = NOP; z = 1'b0; in_valid = 1'b0; resume = 1'b0;
            @(negedge clk);
        end
        nReset = 1'b1;
    endtask

    initial begin
        nReset = 1'b0; opcode = NOP; z = 1'b0; in_valid = 1'b0; resume = 1'b0;

        tbl.push_back(mk(NOP,  0, 0, 0, e(0,0,0,0,1,0,0,0,0)));
        tbl.push_back(mk(ACCI, 0, 1, 0, e(1,0,1,1,1,0,0,0,0)));
        tbl.push_back(mk(ACCI, 0, 0, 0, e(0,0,0,0,0,0,0,0,0)));
        tbl.push_back(mk(ACCI, 0, 0, 0, e(0,0,0,0,0,0,1,0,0)));
        tbl.push_back(mk(ACCI, 0, 0, 0, e(0,0,0,0,0,0,1,0,0)));
        tbl.push_back(mk(HALT, 0, 1, 0, e(1,0,1,1,1,0,1,0,0)));
        tbl.push_back(mk(MACI, 0, 0, 0, e(0,0,0,0,0,0,0,0,0)));
        tbl.push_back(mk(MACI, 0, 0, 0, e(0,0,0,0,0,0,1,0,0)));
        tbl.push_back(mk(MACI, 0, 0, 0, e(0,0,0,0,0,0,1,0,0)));
        tbl.push_back(mk(MACI, 0, 0, 0, e(0,0,0,0,0,0,1,0,0)));
        tbl.push_back(mk(MACI, 0, 0, 0, e(1,1,0,0,1,0,1,0,0)));
        tbl.push_back(mk(BEQ,  1, 0, 0, e(0,0,0,0,0,1,0,0,0)));
        tbl.push_back(mk(BEQ,  0, 0, 0, e(0,0,0,0,1,0,0,0,0)));
        tbl.push_back(mk(BNE,  0, 0, 0, e(0,0,0,0,0,1,0,0,0)));
        tbl.push_back(mk(BNE,  1, 0, 0, e(0,0,0,0,1,0,0,0,0)));
        tbl.push_back(mk(JMP,  0, 0, 0, e(0,0,0,0,0,1,0,0,0)));
        tbl.push_back(mk(JMP,  1, 0, 0, e(0,0,0,0,0,1,0,0,0)));
        tbl.push_back(mk(ILL,  0, 0, 0, e(0,0,0,0,1,0,0,1,0)));
        tbl.push_back(mk(NOP,  0, 0, 0, e(0,0,0,0,1,0,0,0,1)));
        tbl.push_back(mk(NOP,  0, 0, 1, e(0,0,0,0,1,0,0,0,1)));
        tbl.push_back(mk(HALT, 0, 0, 0, e(0,0,0,0,0,0,0,0,1)));
        for (int k = 0; k < 5; k++)
            tbl.push_back(mk(ACCI, 1, 1, 0, e(0,0,0,0,0,0,1,0,1)));
        tbl.push_back(mk(NOP,  0, 0, 1, e(0,0,0,0,1,0,1,0,1)));
        tbl.push_back(mk(NOP,  0, 0, 1, e(0,0,0,0,1,0,0,0,1)));

        #1;
        checks++;
        if (o0 !== 9'd0 || c0 !== 16'd0) begin
            errors++;
            $display("FAIL power_on_reset got=%b cnt=%0d want=0 cnt=0", o0, c0);
        end
        repeat (2) @(negedge clk);
        nReset = 1'b1;

        for (int i = 0; i < tbl.size(); i++)
            step($sformatf("vec%0d", i), tbl[i].op, tbl[i].z, tbl[i].iv, tbl[i].rs, tbl[i].e);

        // Reset while HALTED, then a NOP must retire straight away.
        step("halt_issue", HALT, 0, 0, 0, e(0,0,0,0,0,0,0,0,1));
        step("halted",     HALT, 0, 0, 0, e(0,0,0,0,0,0,1,0,1));
        resume = 1'b1;
        reset_pulse("rst_halted");
        step("nop_after_rst_halted", NOP, 0, 0, 0, e(0,0,0,0,1,0,0,0,0));

        // Reset in the second MAC_BUSY cycle drops the pending accumulate.
        step("mac_issue", MACI, 0, 0, 0, e(0,0,0,0,0,0,0,0,0));
        step("mac_busy1", MACI, 0, 0, 0, e(0,0,0,0,0,0,1,0,0));
        opcode = MACI;
        reset_pulse("rst_mac");
        step("nop_after_rst_mac", NOP, 0, 0, 0, e(0,0,0,0,1,0,0,0,0));
        step("nop_after_rst_mac2", NOP, 0, 0, 0, e(0,0,0,0,1,0,0,0,0));

        // Single-cycle MACI on the MAC_CYCLES=0 instance alongside the issue cycle on dut0.
        reset_pulse("rst_mac0");
        opcode = MACI;
        checks++;
        #2;
        if (o1 !== e(1,1,0,0,1,0,0,0,0)) begin
            errors++;
            $display("FAIL mac0_strobes got=%b want=%b", o1, e(1,1,0,0,1,0,0,0,0));
        end
        @(negedge clk);
        checks++;
        if (c1 !== 16'd1 || o1[2] !== 1'b0) begin
            errors++;
            $display("FAIL mac0_retire cnt=%0d busy=%b want cnt=1 busy=0", c1, o1[2]);
        end

        // Two-bit counter saturates at 3.
        reset_pulse("rst_sat");
        for (int k = 0; k < 6; k++) begin
            logic [1:0] want;
            want = (k > 3) ? 2'd3 : 2'(k);
            step($sformatf("sat_nop%0d", k), NOP, 0, 0, 0, e(0,0,0,0,1,0,0,0,0));
            checks++;
            if (c2 !== ((k + 1 > 3) ? 2'd3 : 2'(k + 1))) begin
                errors++;
                $display("FAIL sat_cnt%0d got=%0d want=%0d (prev %0d)", k, c2,
                         (k + 1 > 3) ? 3 : k + 1, want);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
